// File: rtl/uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : uart_receiver                                              |
// | Description : UART 8N1 receiver. Synchronises the asynchronous serial    |
// |               line, validates the start bit, majority-votes every bit    |
// |               around mid-bit and frames out one byte with a one-cycle    |
// |               data_ready strobe. A low stop bit raises a one-cycle       |
// |               frame_error and the receiver then waits for the line to    |
// |               return high before looking for a new start edge.           |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
// | Ports                                                                    |
// |   clk          in   1  system clock, all logic on posedge                |
// |   rst_n        in   1  synchronous reset, active-low                     |
// |   signal       in   1  asynchronous serial line, idle high               |
// |   data         out  8  last correctly framed byte, LSB received first    |
// |   data_ready   out  1  one-cycle pulse when data updates                 |
// |   frame_error  out  1  one-cycle pulse when the stop bit samples low     |
// |   busy         out  1  high from start-edge detect until back in IDLE    |
// +--------------------------------------------------------------------------+
module uart_receiver #(
  parameter int CLK_FREQ   = 50000000,
  parameter int BAUDRATE   = 240000,
  parameter int OVERSAMPLE = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       signal,
  output logic [7:0] data,
  output logic       data_ready,
  output logic       frame_error,
  output logic       busy
);

  // ------------------------------------------------------------------------
  // Derived constants
  // ------------------------------------------------------------------------
  localparam int c_TICK_RATE    = BAUDRATE * OVERSAMPLE;
  // Rounded division so the tick rate lands as close as possible to the
  // nominal oversampling rate.
  localparam int c_TICK_DIV_RAW = (CLK_FREQ + c_TICK_RATE / 2) / c_TICK_RATE;
  localparam int c_TICK_DIV     = (c_TICK_DIV_RAW < 1) ? 1 : c_TICK_DIV_RAW;
  localparam int c_TICK_W       = (c_TICK_DIV > 1) ? $clog2(c_TICK_DIV) : 1;
  localparam int c_SAMP_W       = $clog2(OVERSAMPLE);

  localparam logic [c_TICK_W-1:0] c_TICK_LAST = c_TICK_W'(c_TICK_DIV - 1);
  localparam logic [c_TICK_W-1:0] c_TICK_ONE  = c_TICK_W'(1);
  localparam logic [c_SAMP_W-1:0] c_SAMP_LAST = c_SAMP_W'(OVERSAMPLE - 1);
  localparam logic [c_SAMP_W-1:0] c_SAMP_ONE  = c_SAMP_W'(1);
  // Three vote points straddling mid-bit; the decision is on the last one.
  localparam logic [c_SAMP_W-1:0] c_SAMP_V0   = c_SAMP_W'(OVERSAMPLE / 2 - 1);
  localparam logic [c_SAMP_W-1:0] c_SAMP_V1   = c_SAMP_W'(OVERSAMPLE / 2);
  localparam logic [c_SAMP_W-1:0] c_SAMP_DEC  = c_SAMP_W'(OVERSAMPLE / 2 + 1);

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd3,
    ST_BREAK = 3'd4
  } state_t;

  // ------------------------------------------------------------------------
  // Registers
  // ------------------------------------------------------------------------
  logic                sync1_q;    // first synchroniser stage
  logic                sig_s_q;    // synchronised line (signal_s)
  logic                sig_d_q;    // signal_s delayed one clock, for edges
  logic [c_TICK_W-1:0] tick_cnt_q;
  logic [c_TICK_W-1:0] tick_cnt_d;
  logic [c_SAMP_W-1:0] samp_q;
  logic [c_SAMP_W-1:0] samp_d;
  logic [2:0]          bit_q;
  logic [7:0]          shift_q;
  logic                vote0_q;
  logic                vote1_q;
  state_t              state_q;
  logic [7:0]          data_q;
  logic                data_ready_q;
  logic                frame_error_q;
  logic                busy_q;

  // ------------------------------------------------------------------------
  // Combinational helpers
  // ------------------------------------------------------------------------
  logic tick;
  logic fall_edge;
  logic decide;
  logic bit_val;

  always_comb begin
    tick       = (tick_cnt_q == '0);
    tick_cnt_d = (tick_cnt_q == c_TICK_LAST) ? '0 : (tick_cnt_q + c_TICK_ONE);
    samp_d     = (samp_q == c_SAMP_LAST) ? '0 : (samp_q + c_SAMP_ONE);
    fall_edge  = sig_d_q & ~sig_s_q;
    decide     = tick & (samp_q == c_SAMP_DEC);
    // Majority of the two stored votes and the line at the decision tick.
    bit_val    = (vote0_q & vote1_q) | (vote0_q & sig_s_q) | (vote1_q & sig_s_q);
  end

  // ------------------------------------------------------------------------
  // Input synchroniser and edge-detect delay. Reset to the idle level so a
  // quiet line does not look like an edge on reset release.
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sig_s_q <= 1'b1;
      sig_d_q <= 1'b1;
    end else begin
      sync1_q <= signal;
      sig_s_q <= sync1_q;
      sig_d_q <= sig_s_q;
    end
  end

  // ------------------------------------------------------------------------
  // Tick generator, sample counter and receive FSM with registered outputs
  // ------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      tick_cnt_q    <= '0;
      samp_q        <= '0;
      bit_q         <= 3'd0;
      shift_q       <= 8'h00;
      vote0_q       <= 1'b0;
      vote1_q       <= 1'b0;
      state_q       <= ST_IDLE;
      data_q        <= 8'h00;
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      data_ready_q  <= 1'b0;
      frame_error_q <= 1'b0;
      tick_cnt_q    <= tick_cnt_d;

      if (tick) begin
        samp_q <= samp_d;
        if (samp_q == c_SAMP_V0) vote0_q <= sig_s_q;
        if (samp_q == c_SAMP_V1) vote1_q <= sig_s_q;
      end

      case (state_q)
        ST_IDLE: begin
          busy_q <= 1'b0;
          if (fall_edge) begin
            // Restart the tick phase on the edge: the first tick fires on
            // the next clock as sample 0 of the start bit, which centres
            // the vote window on mid-bit.
            tick_cnt_q <= '0;
            samp_q     <= '0;
            busy_q     <= 1'b1;
            state_q    <= ST_START;
          end
        end

        ST_START: begin
          if (decide) begin
            if (bit_val) begin
              // Start bit did not hold low: treat as a glitch.
              busy_q  <= 1'b0;
              state_q <= ST_IDLE;
            end else begin
              bit_q   <= 3'd0;
              state_q <= ST_DATA;
            end
          end
        end

        ST_DATA: begin
          if (decide) begin
            shift_q[bit_q] <= bit_val;
            if (bit_q == 3'd7) begin
              state_q <= ST_STOP;
            end else begin
              bit_q <= bit_q + 3'd1;
            end
          end
        end

        ST_STOP: begin
          if (decide) begin
            if (bit_val) begin
              // Leaving at mid-stop-bit lets a back-to-back start edge
              // be caught without any idle time.
              data_q       <= shift_q;
              data_ready_q <= 1'b1;
              busy_q       <= 1'b0;
              state_q      <= ST_IDLE;
            end else begin
              frame_error_q <= 1'b1;
              state_q       <= ST_BREAK;
            end
          end
        end

        ST_BREAK: begin
          // A held-low line must go high before a new start is accepted.
          if (sig_s_q) begin
            busy_q  <= 1'b0;
            state_q <= ST_IDLE;
          end
        end

        default: begin
          busy_q  <= 1'b0;
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign data        = data_q;
  assign data_ready  = data_ready_q;
  assign frame_error = frame_error_q;
  assign busy        = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_receiver.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_uart_receiver                                           |
// | Description : Self-checking bench for uart_receiver. Drives serial       |
// |               frames at nominal and +/-3% rates, glitches, breaks and    |
// |               a mid-frame reset; compares received events against a      |
// |               frame-level reference model.                               |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_uart_receiver;

  localparam int CLK_HALF  = 10;    // 50 MHz
  localparam int BIT_CLKS  = 208;   // 50 MHz / 240 kbaud
  localparam int FAST_CLKS = 202;   // line 3% faster
  localparam int SLOW_CLKS = 215;   // line 3% slower
  localparam int TICK_CLKS = 13;    // one oversample tick

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       line  = 1'b1;
  logic [7:0] data;
  logic       data_ready;
  logic       frame_error;
  logic       busy;

  uart_receiver #(
    .CLK_FREQ  (50000000),
    .BAUDRATE  (240000),
    .OVERSAMPLE(16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .signal     (line),
    .data       (data),
    .data_ready (data_ready),
    .frame_error(frame_error),
    .busy       (busy)
  );

  always #CLK_HALF clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // One event per receiver pulse: fe=0 data_ready with data, fe=1 frame_error
  // with the data value held at that moment.
  typedef struct packed {
    logic       fe;
    logic [7:0] b;
  } ev_t;

  ev_t got_q[$];
  int  got_t[$];
  int  last_t[$];
  ev_t exp_q[$];

  always @(negedge clk) begin
    if (data_ready) begin
      got_q.push_back({1'b0, data});
      got_t.push_back(cyc);
    end
    if (frame_error) begin
      got_q.push_back({1'b1, data});
      got_t.push_back(cyc);
    end
  end

  int         n_tests = 0;
  int         n_fail  = 0;
  logic [7:0] model_data = 8'h00;
  int         last_start = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    n_tests++;
    assert (obs >= lo && obs <= hi) else begin
      n_fail++;
      $error("FAIL %s: observed %0d, expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Frame-level reference: a good stop bit delivers the byte, a low stop bit
  // reports a framing error and leaves the previous byte in place.
  function automatic void model_frame(input logic [7:0] b, input logic stop);
    if (stop) begin
      exp_q.push_back({1'b0, b});
      model_data = b;
    end else begin
      exp_q.push_back({1'b1, model_data});
    end
  endfunction

  // Called at a negedge. The line is left at the stop level when gap_bits==0.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int per,
                            input int gap_bits);
    logic [9:0] fr;
    fr = {stop, b, 1'b0};
    model_frame(b, stop);
    last_start = cyc;
    for (int i = 0; i < 10; i++) begin
      line = fr[i];
      repeat (per) @(negedge clk);
    end
    if (gap_bits > 0) begin
      line = 1'b1;
      repeat (gap_bits * per) @(negedge clk);
    end
  endtask

  task automatic check_events(input string tag);
    int waited;
    waited = 0;
    while (got_q.size() < exp_q.size() && waited < 4 * BIT_CLKS) begin
      @(negedge clk);
      waited++;
    end
    repeat (BIT_CLKS) @(negedge clk);
    check({tag, ".count"}, 32'(got_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check({tag, ".kind"}, 32'(got_q[i].fe), 32'(exp_q[i].fe));
      check({tag, ".data"}, 32'(got_q[i].b), 32'(exp_q[i].b));
    end
    check({tag, ".busy_idle"}, 32'(busy), 32'd0);
    last_t = got_t;
    exp_q.delete();
    got_q.delete();
    got_t.delete();
  endtask

  initial begin
    int per;
    int gap;
    logic stop;
    logic [7:0] b;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset.data", 32'(data), 32'h0);
    check("reset.data_ready", 32'(data_ready), 32'h0);
    check("reset.frame_error", 32'(frame_error), 32'h0);
    check("reset.busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    model_data = 8'h00;
    repeat (2 * BIT_CLKS) @(negedge clk);

    // 1. Single 0x55 at nominal rate, with latency of ~2 clks + 9.5 bits
    send_frame(8'h55, 1'b1, BIT_CLKS, 1);
    check_events("t1_0x55");
    if (last_t.size() > 0)
      check_range("t1.latency", last_t[0] - last_start,
                  2 + 19 * BIT_CLKS / 2 - TICK_CLKS - 4,
                  2 + 19 * BIT_CLKS / 2 + TICK_CLKS + 4);
    else
      check("t1.latency_pulse_seen", 32'(last_t.size()), 32'd1);

    // 2. Back-to-back 0xA5, 0x3C with no idle gap, 10 bit times apart
    send_frame(8'hA5, 1'b1, BIT_CLKS, 0);
    send_frame(8'h3C, 1'b1, BIT_CLKS, 1);
    check_events("t2_b2b");
    if (last_t.size() == 2)
      check_range("t2.spacing", last_t[1] - last_t[0],
                  10 * BIT_CLKS - TICK_CLKS - 2, 10 * BIT_CLKS + TICK_CLKS + 2);
    else
      check("t2.pulse_count", 32'(last_t.size()), 32'd2);

    // 3. Three-tick low glitch, then 0x81
    line = 1'b0;
    repeat (3 * TICK_CLKS) @(negedge clk);
    line = 1'b1;
    // busy rose at the edge detect, a few clocks after the glitch began
    repeat (20 - 3 * TICK_CLKS + 3 * TICK_CLKS) @(negedge clk);
    repeat (0) @(negedge clk);
    check("t3.busy_during_start", 32'(busy), 32'd1);
    repeat (3 * BIT_CLKS / 4 - 20) @(negedge clk);
    check("t3.busy_cleared", 32'(busy), 32'd0);
    check_events("t3_glitch");
    send_frame(8'h81, 1'b1, BIT_CLKS, 1);
    check_events("t3_0x81");

    // 4. 0xF0 with a low stop bit, line held low 30 bits, then 0x12
    send_frame(8'hF0, 1'b0, BIT_CLKS, 0);
    repeat (15 * BIT_CLKS) @(negedge clk);
    check("t4.busy_in_break", 32'(busy), 32'd1);
    repeat (15 * BIT_CLKS) @(negedge clk);
    line = 1'b1;
    repeat (2 * BIT_CLKS) @(negedge clk);
    check_events("t4_break");
    send_frame(8'h12, 1'b1, BIT_CLKS, 1);
    check_events("t4_0x12");

    // 5. One-clock reset during data bit 4 of 0xC3, then 0x7E
    fork
      send_frame(8'hC3, 1'b1, BIT_CLKS, 0);
      begin
        repeat (5 * BIT_CLKS + BIT_CLKS / 2) @(negedge clk);
        check("t5.busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        check("t5.reset_data", 32'(data), 32'h0);
        check("t5.reset_data_ready", 32'(data_ready), 32'h0);
        check("t5.reset_frame_error", 32'(frame_error), 32'h0);
        check("t5.reset_busy", 32'(busy), 32'h0);
        rst_n = 1'b1;
      end
    join
    // Let any resync on the tail of the aborted frame run out, then discard.
    line = 1'b1;
    repeat (8 * BIT_CLKS) @(negedge clk);
    exp_q.delete();
    got_q.delete();
    got_t.delete();
    model_data = 8'h00;
    send_frame(8'h7E, 1'b1, BIT_CLKS, 1);
    check_events("t5_0x7E");

    // 6. 0x96 at +3% and -3% line rate
    send_frame(8'h96, 1'b1, FAST_CLKS, 1);
    check_events("t6_fast");
    send_frame(8'h96, 1'b1, SLOW_CLKS, 1);
    check_events("t6_slow");

    // Randomised frames: byte, rate, gap and occasional bad stop bit
    for (int n = 0; n < 10; n++) begin
      b = 8'($urandom);
      stop = ($urandom_range(0, 7) != 0);
      case ($urandom_range(0, 2))
        0:       per = BIT_CLKS;
        1:       per = FAST_CLKS;
        default: per = SLOW_CLKS;
      endcase
      gap = stop ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
      send_frame(b, stop, per, gap);
    end
    line = 1'b1;
    check_events("rand");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Global watchdog so the run always ends.
  initial begin
    repeat (200000) @(posedge clk);
    $display("FAIL watchdog: observed timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
